// File: rtl/enigma_stream_core.sv
// Enigma cipher core: N stepping rotors (types I-V) with ring settings and reflector B.
// One rotor is applied per cycle; symbols and rotor configuration move over valid/ready handshakes.
module enigma_stream_core #(
    parameter int NUM_ROTORS = 3,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [2:0]       cfg_type,
    input  logic [4:0]       cfg_pos,
    input  logic [4:0]       cfg_ring,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_sym,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_sym,
    output logic [4:0]       debug_out
);
    localparam int CW = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_ROTORS - 1);

    localparam logic [207:0] W_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] W_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] W_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] W_IV  = "ESOVPZJAYQUIRHXLNFTGKWBMDC";
    localparam logic [207:0] W_V   = "VZBRGITYUPSDNHLWMFCJQKAXEO";
    localparam logic [207:0] REF_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STEP = 3'd1,
        S_FWD  = 3'd2,
        S_REFL = 3'd3,
        S_BWD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Letter tables hold ASCII with the first letter in the top byte.
    function automatic logic [4:0] tbl_lookup(input logic [207:0] tbl, input logic [4:0] x);
        logic [4:0] xs;
        logic [7:0] ch;
        xs = (x > 5'd25) ? 5'd0 : x;
        ch = 8'(tbl >> (8'd8 * (8'd25 - {3'b000, xs})));
        return 5'(ch - 8'd65);
    endfunction

    function automatic logic [4:0] rot_fwd(input logic [2:0] t, input logic [4:0] x);
        logic [207:0] tbl;
        case (t)
            3'd0:    tbl = W_I;
            3'd1:    tbl = W_II;
            3'd2:    tbl = W_III;
            3'd3:    tbl = W_IV;
            3'd4:    tbl = W_V;
            default: tbl = W_I;
        endcase
        return tbl_lookup(tbl, x);
    endfunction

    function automatic logic [4:0] rot_bwd(input logic [2:0] t, input logic [4:0] y);
        logic [4:0] r;
        r = 5'd0;
        for (int j = 0; j < 26; j++) begin
            if (rot_fwd(t, 5'(j)) == y) begin
                r = 5'(j);
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] notch_of(input logic [2:0] t);
        case (t)
            3'd0:    return 5'd16;
            3'd1:    return 5'd4;
            3'd2:    return 5'd21;
            3'd3:    return 5'd9;
            3'd4:    return 5'd25;
            default: return 5'd25;
        endcase
    endfunction

    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
    endfunction

    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   idx_r;
    logic [4:0]      pos_r  [NUM_ROTORS];
    logic [4:0]      ring_r [NUM_ROTORS];
    logic [2:0]      type_r [NUM_ROTORS];
    logic [4:0]      sym_r, out_r;
    logic            pass_r;

    logic [NUM_ROTORS-1:0] notch_s, step_s;
    logic [4:0]      sel_pos_s, sel_ring_s, shift_s, sym_in_s, ent_s;
    logic [4:0]      fwd_s, bwd_s, refl_s;
    logic [2:0]      sel_type_s;
    logic            cfg_ok_s;

    assign cfg_ok_s = cfg_we && cfg_ready && (int'(cfg_idx) < NUM_ROTORS) &&
                      (cfg_type <= 3'd4) && (cfg_pos <= 5'd25) && (cfg_ring <= 5'd25);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = in_valid ? S_STEP : S_IDLE;
            S_STEP:  state_s = S_FWD;
            S_FWD:   state_s = (idx_r == LAST_IDX) ? S_REFL : S_FWD;
            S_REFL:  state_s = S_BWD;
            S_BWD:   state_s = (idx_r == '0) ? S_DONE : S_BWD;
            S_DONE:  state_s = out_ready ? S_IDLE : S_DONE;
            default: state_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            S_IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
            end
            S_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Stepping decisions use pre-step positions; middle rotors double-step on their own notch.
    always_comb begin
        for (int i = 0; i < NUM_ROTORS; i++) begin
            notch_s[i] = (pos_r[i] == notch_of(type_r[i]));
        end
        step_s[0] = 1'b1;
        for (int i = 1; i < NUM_ROTORS; i++) begin
            step_s[i] = notch_s[i-1] | ((i < NUM_ROTORS - 1) ? notch_s[i] : 1'b0);
        end
    end

    // Substitution through the rotor currently addressed by idx_r.
    always_comb begin
        sel_pos_s  = pos_r[idx_r];
        sel_ring_s = ring_r[idx_r];
        sel_type_s = type_r[idx_r];
        sym_in_s   = pass_r ? 5'd0 : sym_r;
        shift_s    = sub26(sel_pos_s, sel_ring_s);
        ent_s      = add26(sym_in_s, shift_s);
        fwd_s      = sub26(rot_fwd(sel_type_s, ent_s), shift_s);
        bwd_s      = sub26(rot_bwd(sel_type_s, ent_s), shift_s);
        refl_s     = tbl_lookup(REF_B, sym_in_s);
    end

    // Rotor configuration and positions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                pos_r[i]  <= 5'd0;
                ring_r[i] <= 5'd0;
                type_r[i] <= 3'((NUM_ROTORS - 1 - i) % 5);
            end
        end else if (state_r == S_STEP && !pass_r) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                if (step_s[i]) begin
                    pos_r[i] <= (pos_r[i] == 5'd25) ? 5'd0 : pos_r[i] + 5'd1;
                end
            end
        end else if (cfg_ok_s) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    pos_r[i]  <= cfg_pos;
                    ring_r[i] <= cfg_ring;
                    type_r[i] <= cfg_type;
                end
            end
        end
    end

    // Symbol datapath; out-of-alphabet symbols ride through the sequence untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_r  <= 5'd0;
            out_r  <= 5'd0;
            pass_r <= 1'b0;
            idx_r  <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        sym_r  <= in_sym;
                        pass_r <= (in_sym > 5'd25);
                    end
                end
                S_STEP: idx_r <= '0;
                S_FWD: begin
                    if (!pass_r) sym_r <= fwd_s;
                    idx_r <= idx_r + CW'(1);
                end
                S_REFL: begin
                    if (!pass_r) sym_r <= refl_s;
                    idx_r <= LAST_IDX;
                end
                S_BWD: begin
                    if (!pass_r) sym_r <= bwd_s;
                    if (idx_r == '0) begin
                        out_r <= pass_r ? sym_r : bwd_s;
                    end else begin
                        idx_r <= idx_r - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_sym   = out_r;
    assign debug_out = pos_r[0];

endmodule
